rw_step_driver: RTL and testbench

RW_STEP_DRIVER -- requirements
Module: rw_step_driver

---
 rtl/rw_driver_pkg.sv | 14 +
 rtl/rw_bit_serdes.sv | 54 +++++
 rtl/rw_step_driver.sv | 110 +++++++++++
 tb/tb_rw_step_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_driver_pkg.sv
// Shared types and constants for the reactive-device step driver.
package rw_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int DATA_W_DEFAULT = 8;
  localparam int STEP_CNT_W     = 16;

endpackage

// File: rtl/rw_bit_serdes.sv
// Shift-out / collect register pair with a shared bit index.
// Words leave LSB first; the device response for step k lands in collect bit k.
module rw_bit_serdes #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              dev_out,
  output logic              bit_out,
  output logic [DATA_W-1:0] collect,
  output logic              last
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] collect_q, collect_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    shift_d   = shift_q;
    collect_d = collect_q;
    idx_d     = idx_q;
    if (load) begin
      shift_d   = load_data;
      collect_d = '0;
      idx_d     = '0;
    end else if (shift_en) begin
      collect_d[idx_q] = dev_out;
      shift_d          = {1'b0, shift_q[DATA_W-1:1]};
      idx_d            = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      collect_q <= '0;
      idx_q     <= '0;
    end else begin
      shift_q   <= shift_d;
      collect_q <= collect_d;
      idx_q     <= idx_d;
    end
  end

  assign bit_out = shift_q[0];
  assign collect = collect_q;
  assign last    = (idx_q == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/rw_step_driver.sv
// Steps a reactive device one bit per cycle from an input word and returns its outputs as a word.
// Optional step counter enabled by defining RW_STEP_DRIVER_STATS_EN.
module rw_step_driver
  import rw_driver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  dev_in,
  input  logic                  dev_out,
  input  logic                  dev_continue,
  output logic                  m_valid,
  output logic [DATA_W-1:0]     m_data,
  input  logic                  m_ready,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] bits_stepped
);

  state_t            state_q, state_d;
  logic              term_q, term_d;
  logic              load;
  logic              shift_en;
  logic              ser_bit;
  logic              ser_last;
  logic [DATA_W-1:0] ser_collect;

  rw_bit_serdes #(.DATA_W(DATA_W)) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (s_data),
    .dev_out   (dev_out),
    .bit_out   (ser_bit),
    .collect   (ser_collect),
    .last      (ser_last)
  );

  // A terminating device still contributes the bit of the step it stopped on.
  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!dev_continue) begin
          state_d = HALT;
        end else if (s_valid) begin
          load    = 1'b1;
          term_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (!dev_continue) begin
          term_d  = 1'b1;
          state_d = FLUSH;
        end else if (ser_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (m_ready) state_d = term_q ? HALT : IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign dev_in  = (state_q == SHIFT) & ser_bit;
  assign m_valid = (state_q == FLUSH);
  assign m_data  = (state_q == FLUSH) ? ser_collect : '0;
  assign done    = (state_q == HALT);

`ifdef RW_STEP_DRIVER_STATS_EN
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (state_q == SHIFT && step_cnt_q != '1) step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_cnt_q <= '0;
    else     step_cnt_q <= step_cnt_d;
  end

  assign bits_stepped = step_cnt_q;
`else
  assign bits_stepped = '0;
`endif

endmodule

// File: tb/tb_rw_step_driver.sv
// Randomized self-checking bench for rw_step_driver against a word-level device model.
// Counter checks follow RW_STEP_DRIVER_STATS_EN.
module tb_rw_step_driver;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          dev_in;
  logic          dev_out;
  logic          dev_continue;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          done;
  logic [15:0]   bits_stepped;
  logic          dev_mode;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] obs_din;
  logic [DW-1:0] obs_data;
  int            obs_lat;
  logic          obs_stable;
  logic          obs_busy_ready;
  logic          obs_after_ready;
  logic          obs_after_done;
  logic          obs_after_mvalid;

  // Device under drive: a stateless echo (mode 0) or inverter (mode 1).
  assign dev_out = dev_in ^ dev_mode;

  always #5 clk = ~clk;

  rw_step_driver #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .dev_in       (dev_in),
    .dev_out      (dev_out),
    .dev_continue (dev_continue),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .done         (done),
    .bits_stepped (bits_stepped)
  );

  // Word-level expectation: steps 0..n-1 collect the device reply, the rest stay zero.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] word, input logic inv,
                                               input int term_step);
    int n;
    logic [DW-1:0] r;
    n = (term_step < 0 || term_step >= DW) ? DW : term_step + 1;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = word[k] ^ inv;
    return r;
  endfunction

  function automatic int model_latency(input int term_step);
    int n;
    n = (term_step < 0 || term_step >= DW) ? DW : term_step + 1;
    return n + 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    s_valid      = 1'b0;
    m_ready      = 1'b0;
    dev_continue = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Offers one word, records what the driver does, then accepts the result after hold cycles.
  task automatic run_word(input logic [DW-1:0] word, input int term_step, input int hold);
    int cyc;
    @(negedge clk);
    s_valid          = 1'b1;
    s_data           = word;
    dev_continue     = 1'b1;
    obs_din          = '0;
    obs_data         = '0;
    obs_lat          = -1;
    obs_stable       = 1'b1;
    obs_busy_ready   = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    cyc     = 1;
    while (cyc < 40 && obs_lat < 0) begin
      @(negedge clk);
      if (m_valid) begin
        obs_lat  = cyc;
        obs_data = m_data;
      end else begin
        if (s_ready) obs_busy_ready = 1'b1;
        if (cyc - 1 < DW) obs_din[3'(cyc - 1)] = dev_in;
        dev_continue = (cyc - 1 == term_step) ? 1'b0 : 1'b1;
        @(posedge clk);
        cyc++;
      end
    end
    dev_continue = 1'b1;
    s_valid      = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== obs_data) obs_stable = 1'b0;
      if (s_ready) obs_busy_ready = 1'b1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    obs_after_ready  = s_ready;
    obs_after_done   = done;
    obs_after_mvalid = m_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; dev_continue = 1'b1; dev_mode = 1'b0;
    #3;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (dev_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_dev_in got %b want 0", dev_in); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_data got %h want 00", m_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (bits_stepped !== 16'h0) begin errors++; $display("[TB] FAIL reset_bits got %h want 0000", bits_stepped); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_echo();
    do_reset();
    dev_mode = 1'b0;
    run_word(8'hA5, -1, 0);
    checks++; if (obs_din !== 8'hA5) begin errors++; $display("[TB] FAIL echo_dev_in_seq got %h want a5", obs_din); end
    checks++; if (obs_lat != 9) begin errors++; $display("[TB] FAIL echo_latency got %0d want 9", obs_lat); end
    checks++; if (obs_data !== 8'hA5) begin errors++; $display("[TB] FAIL echo_m_data got %h want a5", obs_data); end
    checks++; if (obs_after_ready !== 1'b1) begin errors++; $display("[TB] FAIL echo_ready_after got %b want 1", obs_after_ready); end
  endtask

  task automatic test_invert_hold();
    do_reset();
    dev_mode = 1'b1;
    run_word(8'h0F, -1, 5);
    checks++; if (obs_data !== 8'hF0) begin errors++; $display("[TB] FAIL invert_m_data got %h want f0", obs_data); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("[TB] FAIL invert_hold_stable got %b want 1", obs_stable); end
    checks++; if (obs_busy_ready !== 1'b0) begin errors++; $display("[TB] FAIL invert_busy_ready got %b want 0", obs_busy_ready); end
    checks++; if (obs_after_ready !== 1'b1) begin errors++; $display("[TB] FAIL invert_ready_after got %b want 1", obs_after_ready); end
    checks++; if (obs_after_mvalid !== 1'b0) begin errors++; $display("[TB] FAIL invert_mvalid_after got %b want 0", obs_after_mvalid); end
  endtask

  task automatic test_random_words();
    logic [DW-1:0] w;
    logic [DW-1:0] exp;
    int hold;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w        = DW'($urandom);
      dev_mode = 1'($urandom);
      hold     = int'($urandom_range(0, 3));
      exp      = model_word(w, dev_mode, -1);
      run_word(w, -1, hold);
      checks++; if (obs_data !== exp) begin errors++; $display("[TB] FAIL rand_m_data[%0d] got %h want %h", i, obs_data, exp); end
      checks++; if (obs_din !== w) begin errors++; $display("[TB] FAIL rand_dev_in[%0d] got %h want %h", i, obs_din, w); end
      checks++; if (obs_lat != model_latency(-1)) begin errors++; $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", i, obs_lat, model_latency(-1)); end
      checks++; if (obs_stable !== 1'b1 || obs_busy_ready !== 1'b0) begin errors++; $display("[TB] FAIL rand_hold[%0d] got stable=%b busy_ready=%b want 1/0", i, obs_stable, obs_busy_ready); end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_mv;
    logic [DW-1:0] w;
    do_reset();
    dev_mode = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (dev_in !== 1'b1) begin errors++; $display("[TB] FAIL midrst_step4_bit got %b want 1", dev_in); end
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1 || dev_in !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00)
      begin errors++; $display("[TB] FAIL midrst_outputs got rdy=%b din=%b mv=%b md=%h want 1/0/0/00", s_ready, dev_in, m_valid, m_data); end
    saw_mv = 1'b0;
    repeat (3) begin @(negedge clk); if (m_valid) saw_mv = 1'b1; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (m_valid) saw_mv = 1'b1; end
    checks++; if (saw_mv !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_mvalid got %b want 0", saw_mv); end
    w = DW'($urandom);
    run_word(w, -1, 1);
    checks++; if (obs_data !== w) begin errors++; $display("[TB] FAIL midrst_next_word got %h want %h", obs_data, w); end
  endtask

  task automatic test_term_mid();
    logic bad;
    do_reset();
    dev_mode = 1'b0;
    run_word(8'hFF, 3, 2);
    checks++; if (obs_data !== model_word(8'hFF, 1'b0, 3)) begin errors++; $display("[TB] FAIL term3_m_data got %h want %h", obs_data, model_word(8'hFF, 1'b0, 3)); end
    checks++; if (obs_lat != model_latency(3)) begin errors++; $display("[TB] FAIL term3_latency got %0d want %0d", obs_lat, model_latency(3)); end
    checks++; if (obs_after_done !== 1'b1 || obs_after_ready !== 1'b0) begin errors++; $display("[TB] FAIL term3_halt got done=%b rdy=%b want 1/0", obs_after_done, obs_after_ready); end
    bad = 1'b0;
    s_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || done !== 1'b1 || dev_in !== 1'b0) bad = 1'b1;
    end
    s_valid = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL term3_halt_sticky got %b want 0", bad); end
  endtask

  task automatic test_term_last();
    logic [DW-1:0] w;
    do_reset();
    dev_mode = 1'b1;
    w = DW'($urandom);
    run_word(w, 7, 0);
    checks++; if (obs_data !== model_word(w, 1'b1, 7)) begin errors++; $display("[TB] FAIL term7_m_data got %h want %h", obs_data, model_word(w, 1'b1, 7)); end
    checks++; if (obs_after_done !== 1'b1 || obs_after_ready !== 1'b0) begin errors++; $display("[TB] FAIL term7_halt got done=%b rdy=%b want 1/0", obs_after_done, obs_after_ready); end
  endtask

  task automatic test_term_idle();
    logic saw_mv;
    do_reset();
    @(negedge clk);
    dev_continue = 1'b0;
    saw_mv = 1'b0;
    repeat (4) begin @(negedge clk); if (m_valid) saw_mv = 1'b1; end
    dev_continue = 1'b1;
    s_valid = 1'b1;
    repeat (4) begin @(negedge clk); if (m_valid) saw_mv = 1'b1; end
    s_valid = 1'b0;
    checks++; if (done !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_term got done=%b rdy=%b want 1/0", done, s_ready); end
    checks++; if (saw_mv !== 1'b0) begin errors++; $display("[TB] FAIL idle_term_mvalid got %b want 0", saw_mv); end
  endtask

  task automatic test_stats();
    do_reset();
    dev_mode = 1'b0;
    for (int i = 0; i < 3; i++) run_word(DW'($urandom), -1, 0);
`ifdef RW_STEP_DRIVER_STATS_EN
    checks++; if (bits_stepped !== 16'd24) begin errors++; $display("[TB] FAIL stats_three_words got %0d want 24", bits_stepped); end
    @(negedge clk);
    force dut.step_cnt_q = 16'hFFFE;
    #1;
    release dut.step_cnt_q;
    run_word(DW'($urandom), -1, 0);
    checks++; if (bits_stepped !== 16'hFFFF) begin errors++; $display("[TB] FAIL stats_saturate got %h want ffff", bits_stepped); end
`else
    checks++; if (bits_stepped !== 16'h0) begin errors++; $display("[TB] FAIL stats_disabled got %h want 0000", bits_stepped); end
`endif
  endtask

  initial begin
    test_reset();
    test_echo();
    test_invert_hold();
    test_random_words();
    test_reset_mid();
    test_stats();
    test_term_last();
    test_term_mid();
    test_term_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
